// File: rtl/desc_tile_scheduler_if.sv
// Bundles the descriptor-stream, DMA-command and compute-control signals of
// desc_tile_scheduler; master is the scheduler, slave is its environment.
interface desc_tile_scheduler_if;
  logic        start;
  logic [31:0] desc_word;
  logic        desc_valid;
  logic        desc_ready;
  logic        dma_cmd_valid;
  logic        dma_cmd_ready;
  logic [31:0] dma_dram_addr;
  logic [15:0] dma_sram_addr;
  logic [15:0] dma_length;
  logic [15:0] dma_stride;
  logic [1:0]  dma_buf_id;
  logic        dma_done;
  logic        comp_start;
  logic [1:0]  comp_buf_id;
  logic [15:0] comp_tile_h;
  logic [15:0] comp_tile_w;
  logic [15:0] comp_c_in;
  logic [7:0]  comp_flags;
  logic        comp_done;
  logic        layer_done;
  logic        busy;
  logic        err_no_weight;
  logic [15:0] tile_count;
  logic [2:0]  dbg_state;

  modport master (
    input  start, desc_word, desc_valid, dma_cmd_ready, dma_done, comp_done,
    output desc_ready, dma_cmd_valid, dma_dram_addr, dma_sram_addr, dma_length,
           dma_stride, dma_buf_id, comp_start, comp_buf_id, comp_tile_h,
           comp_tile_w, comp_c_in, comp_flags, layer_done, busy,
           err_no_weight, tile_count, dbg_state
  );

  modport slave (
    output start, desc_word, desc_valid, dma_cmd_ready, dma_done, comp_done,
    input  desc_ready, dma_cmd_valid, dma_dram_addr, dma_sram_addr, dma_length,
           dma_stride, dma_buf_id, comp_start, comp_buf_id, comp_tile_h,
           comp_tile_w, comp_c_in, comp_flags, layer_done, busy,
           err_no_weight, tile_count, dbg_state
  );
endinterface

// File: rtl/desc_tile_scheduler.sv
// Layer sequencer: assembles 256-bit descriptors from a word stream, issues one
// DMA load per descriptor and kicks compute for activation tiles once weights are resident.
module desc_tile_scheduler #(
  parameter int MAX_TILES  = 65535,
  parameter int DESC_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  desc_tile_scheduler_if.master bus
);
  // Handshakes: a beat/command transfers on a rising clk edge where valid and
  // ready are both high; dma_cmd_valid, once raised, holds with stable fields
  // until that edge. done/start inputs are single-cycle pulses.
  localparam int CNT_W  = $clog2(DESC_WORDS);
  localparam int DESC_W = 32 * DESC_WORDS;

  localparam logic [1:0] BUF_ACTBUF_A = 2'b00;
  localparam logic [1:0] BUF_ACTBUF_B = 2'b01;
  localparam logic [1:0] BUF_WGTBUF   = 2'b10;
  localparam int FLAG_IS_WEIGHT    = 0;
  localparam int FLAG_IS_LAST_TILE = 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COLLECT    = 3'd1,
    S_ISSUE_DMA  = 3'd2,
    S_WAIT_DMA   = 3'd3,
    S_START_COMP = 3'd4,
    S_WAIT_COMP  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [DESC_W-1:0]  desc_q, desc_d;
  logic               wgt_loaded_q, wgt_loaded_d;
  logic               act_sel_q, act_sel_d;
  logic [15:0]        tile_count_q, tile_count_d;
  logic               err_q, err_d;
  logic               layer_done_q, layer_done_d;
  logic [1:0]         comp_buf_id_q, comp_buf_id_d;
  logic [15:0]        comp_tile_h_q, comp_tile_h_d;
  logic [15:0]        comp_tile_w_q, comp_tile_w_d;
  logic [15:0]        comp_c_in_q, comp_c_in_d;
  logic [7:0]         comp_flags_q, comp_flags_d;
  logic               dma_finish;

  // descriptor_t field map
  logic [31:0] f_dram;
  logic [15:0] f_sram, f_len, f_stride, f_tile_h, f_tile_w, f_c_in;
  logic [7:0]  f_flags;
  logic        f_is_wgt, f_is_last;
  logic [1:0]  act_buf;

  assign f_dram    = desc_q[255:224];
  assign f_sram    = desc_q[223:208];
  assign f_len     = desc_q[207:192];
  assign f_stride  = desc_q[191:176];
  assign f_tile_h  = desc_q[175:160];
  assign f_tile_w  = desc_q[159:144];
  assign f_c_in    = desc_q[143:128];
  assign f_flags   = desc_q[15:8];
  assign f_is_wgt  = f_flags[FLAG_IS_WEIGHT];
  assign f_is_last = f_flags[FLAG_IS_LAST_TILE];
  assign act_buf   = act_sel_q ? BUF_ACTBUF_B : BUF_ACTBUF_A;

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    desc_d        = desc_q;
    wgt_loaded_d  = wgt_loaded_q;
    act_sel_d     = act_sel_q;
    tile_count_d  = tile_count_q;
    err_d         = err_q;
    layer_done_d  = 1'b0;
    comp_buf_id_d = comp_buf_id_q;
    comp_tile_h_d = comp_tile_h_q;
    comp_tile_w_d = comp_tile_w_q;
    comp_c_in_d   = comp_c_in_q;
    comp_flags_d  = comp_flags_q;
    dma_finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_COLLECT;
          word_cnt_d   = '0;
          tile_count_d = '0;
          err_d        = 1'b0;
          wgt_loaded_d = 1'b0;
          act_sel_d    = 1'b0;
        end
      end
      S_COLLECT: begin
        if (bus.desc_valid) begin
          // word0 ends up in the top 32 bits after DESC_WORDS shifts
          desc_d = {desc_q[DESC_W-33:0], bus.desc_word};
          if (word_cnt_q == CNT_W'(DESC_WORDS - 1)) begin
            word_cnt_d = '0;
            state_d    = S_ISSUE_DMA;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_ISSUE_DMA: begin
        if (f_len == 16'd0) begin
          dma_finish = 1'b1;
        end else if (bus.dma_cmd_ready) begin
          state_d = S_WAIT_DMA;
        end
      end
      S_WAIT_DMA: begin
        if (bus.dma_done) dma_finish = 1'b1;
      end
      S_START_COMP: begin
        state_d = S_WAIT_COMP;
      end
      S_WAIT_COMP: begin
        if (bus.comp_done) begin
          if (tile_count_q != 16'(MAX_TILES)) tile_count_d = tile_count_q + 16'd1;
          act_sel_d = ~act_sel_q;
          if (f_is_last) begin
            layer_done_d = 1'b1;
            wgt_loaded_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared completion path for a real dma_done and a skipped zero-length load
    if (dma_finish) begin
      if (f_is_wgt) begin
        wgt_loaded_d = 1'b1;
        state_d      = S_COLLECT;
      end else if (wgt_loaded_q) begin
        state_d       = S_START_COMP;
        comp_buf_id_d = act_buf;
        comp_tile_h_d = f_tile_h;
        comp_tile_w_d = f_tile_w;
        comp_c_in_d   = f_c_in;
        comp_flags_d  = f_flags;
      end else begin
        err_d   = 1'b1;
        state_d = S_COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      desc_q        <= '0;
      wgt_loaded_q  <= 1'b0;
      act_sel_q     <= 1'b0;
      tile_count_q  <= '0;
      err_q         <= 1'b0;
      layer_done_q  <= 1'b0;
      comp_buf_id_q <= '0;
      comp_tile_h_q <= '0;
      comp_tile_w_q <= '0;
      comp_c_in_q   <= '0;
      comp_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      desc_q        <= desc_d;
      wgt_loaded_q  <= wgt_loaded_d;
      act_sel_q     <= act_sel_d;
      tile_count_q  <= tile_count_d;
      err_q         <= err_d;
      layer_done_q  <= layer_done_d;
      comp_buf_id_q <= comp_buf_id_d;
      comp_tile_h_q <= comp_tile_h_d;
      comp_tile_w_q <= comp_tile_w_d;
      comp_c_in_q   <= comp_c_in_d;
      comp_flags_q  <= comp_flags_d;
    end
  end

  assign bus.desc_ready    = (state_q == S_COLLECT);
  assign bus.dma_cmd_valid = (state_q == S_ISSUE_DMA) && (f_len != 16'd0);
  assign bus.dma_dram_addr = f_dram;
  assign bus.dma_sram_addr = f_sram;
  assign bus.dma_length    = f_len;
  assign bus.dma_stride    = f_stride;
  assign bus.dma_buf_id    = f_is_wgt ? BUF_WGTBUF : act_buf;
  assign bus.comp_start    = (state_q == S_START_COMP);
  assign bus.comp_buf_id   = comp_buf_id_q;
  assign bus.comp_tile_h   = comp_tile_h_q;
  assign bus.comp_tile_w   = comp_tile_w_q;
  assign bus.comp_c_in     = comp_c_in_q;
  assign bus.comp_flags    = comp_flags_q;
  assign bus.layer_done    = layer_done_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.err_no_weight = err_q;
  assign bus.tile_count    = tile_count_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_desc_tile_scheduler.sv
// Directed bench for desc_tile_scheduler: a descriptor-level model predicts DMA
// commands, compute kicks and layer ends; a negedge monitor checks every event.
module tb_desc_tile_scheduler;
  logic clk;
  logic rst_n;
  desc_tile_scheduler_if bus();

  desc_tile_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (actual=running required=done)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [81:0] exp_dma_q[$];   // {dram, sram, len, stride, buf}
  logic [58:0] exp_comp_q[$];  // {zero_len, buf, h, w, c_in, flags}
  logic [15:0] exp_ld_q[$];    // tile_count at each layer_done
  bit          m_wgt, m_act, m_err;
  logic [15:0] m_tiles;

  task automatic model_start();
    m_wgt = 0; m_act = 0; m_err = 0; m_tiles = 16'd0;
  endtask

  task automatic model_desc(input logic [31:0] dram, input logic [15:0] sram, input logic [15:0] len,
                            input logic [15:0] stride, input logic [15:0] h, input logic [15:0] w,
                            input logic [15:0] c, input logic [7:0] flags);
    logic [1:0] b;
    b = flags[0] ? 2'b10 : {1'b0, m_act};
    if (len != 16'd0) exp_dma_q.push_back({dram, sram, len, stride, b});
    if (flags[0]) begin
      m_wgt = 1;
    end else if (m_wgt) begin
      exp_comp_q.push_back({(len == 16'd0), b, h, w, c, flags});
      if (m_tiles != 16'hFFFF) m_tiles = m_tiles + 16'd1;
      m_act = ~m_act;
      if (flags[1]) begin
        exp_ld_q.push_back(m_tiles);
        m_wgt = 0;
      end
    end else begin
      m_err = 1;
    end
  endtask

  // ---------------- environment responder ----------------
  int stall_n = 0;
  bit comp_en = 1;
  bit inject_comp = 0;

  initial begin : responder
    int dma_wait, comp_wait;
    bit hs, cs, vs;
    dma_wait = 0; comp_wait = 0;
    forever begin
      @(negedge clk);
      hs = bus.dma_cmd_valid && bus.dma_cmd_ready;
      cs = bus.comp_start;
      vs = bus.dma_cmd_valid && !bus.dma_cmd_ready;
      @(posedge clk); #1;
      bus.dma_done = 1'b0;
      bus.comp_done = 1'b0;
      if (!rst_n) begin dma_wait = 0; comp_wait = 0; end
      if (dma_wait > 0) begin dma_wait--; if (dma_wait == 0) bus.dma_done = 1'b1; end
      if (comp_wait > 0) begin comp_wait--; if (comp_wait == 0) bus.comp_done = 1'b1; end
      if (inject_comp) begin bus.comp_done = 1'b1; inject_comp = 0; end
      if (hs && rst_n) dma_wait = 3;
      if (cs && comp_en && rst_n) comp_wait = 4;
      if (vs && stall_n > 0) stall_n--;
      bus.dma_cmd_ready = (stall_n == 0);
    end
  end

  // ---------------- monitor / compare ----------------
  int cyc = 0, last_beat_cyc = -100, last_dma_done_cyc = -100, last_comp_done_cyc = -100;
  int ld_count = 0, comp_count = 0, stall_seen = 0;
  logic [1:0]  act_buf_log[$];
  logic [1:0]  last_dma_buf;
  logic [15:0] last_dma_len;

  initial begin : monitor
    bit prev_valid, prev_ready;
    logic [81:0] prev_rec, rec, e;
    logic [58:0] ce;
    logic [15:0] le;
    prev_valid = 0; prev_ready = 0; prev_rec = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin prev_valid = 0; continue; end
      rec = {bus.dma_dram_addr, bus.dma_sram_addr, bus.dma_length, bus.dma_stride, bus.dma_buf_id};
      if (bus.dma_cmd_valid && !prev_valid) chk("dma_valid_latency", 128'(cyc - last_beat_cyc), 128'd1);
      if (prev_valid && !prev_ready) begin
        chk("dma_hold_valid", 128'(bus.dma_cmd_valid), 128'd1);
        chk("dma_hold_fields", 128'(rec), 128'(prev_rec));
      end
      if (bus.dma_cmd_valid && !bus.dma_cmd_ready) stall_seen++;
      if (bus.dma_cmd_valid && bus.dma_cmd_ready) begin
        e = exp_dma_q.size() > 0 ? exp_dma_q.pop_front() : '1;
        chk("dma_cmd", 128'(rec), 128'(e));
        last_dma_buf = bus.dma_buf_id;
        last_dma_len = bus.dma_length;
        if (bus.dma_buf_id != 2'b10) act_buf_log.push_back(bus.dma_buf_id);
      end
      if (bus.comp_start) begin
        comp_count++;
        ce = exp_comp_q.size() > 0 ? exp_comp_q.pop_front() : '1;
        chk("comp_fields", 128'({bus.comp_buf_id, bus.comp_tile_h, bus.comp_tile_w, bus.comp_c_in, bus.comp_flags}),
            128'(ce[57:0]));
        if (ce[58]) chk("comp_latency_zero_len", 128'(cyc - last_beat_cyc), 128'd2);
        else        chk("comp_latency", 128'(cyc - last_dma_done_cyc), 128'd1);
      end
      if (bus.layer_done) begin
        ld_count++;
        le = exp_ld_q.size() > 0 ? exp_ld_q.pop_front() : 16'hDEAD;
        chk("layer_done_tiles", 128'(bus.tile_count), 128'(le));
        chk("layer_done_latency", 128'(cyc - last_comp_done_cyc), 128'd1);
      end
      if (bus.dma_done) last_dma_done_cyc = cyc;
      if (bus.comp_done) last_comp_done_cyc = cyc;
      if (bus.desc_valid && bus.desc_ready) last_beat_cyc = cyc;
      prev_valid = bus.dma_cmd_valid;
      prev_ready = bus.dma_cmd_ready;
      prev_rec = rec;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    model_start();
    chk("start_busy", 128'(bus.busy), 128'd1);
    chk("start_desc_ready", 128'(bus.desc_ready), 128'd1);
  endtask

  task automatic wait_settle(input string name);
    int t = 0;
    while (!(bus.desc_ready || !bus.busy) && t < 300) begin tick(); t++; end
    if (t >= 300) chk(name, 128'd0, 128'd1);
  endtask

  task automatic send_desc(input logic [31:0] dram, input logic [15:0] len, input logic [15:0] h,
                           input logic [15:0] w, input logic [15:0] c, input logic [7:0] flags,
                           input bit wait_done);
    logic [255:0] d;
    logic [15:0]  sram, stride;
    int t;
    sram = dram[19:4] ^ 16'h0A50;
    stride = w + 16'd4;
    d = '0;
    d[255:224] = dram; d[223:208] = sram; d[207:192] = len; d[191:176] = stride;
    d[175:160] = h; d[159:144] = w; d[143:128] = c; d[15:8] = flags;
    model_desc(dram, sram, len, stride, h, w, c, flags);
    for (int i = 0; i < 8; i++) begin
      bus.desc_word = d[255 - 32*i -: 32];
      bus.desc_valid = 1'b1;
      t = 0;
      while (!bus.desc_ready && t < 300) begin tick(); t++; end
      if (t >= 300) chk("desc_ready_timeout", 128'd0, 128'd1);
      tick();
    end
    bus.desc_valid = 1'b0;
    chk("desc_ready_drop", 128'(bus.desc_ready), 128'd0);
    if (wait_done) wait_settle("desc_done_timeout");
  endtask

  task automatic chk_model_state(input string tag);
    chk({tag, "_tile_count"}, 128'(bus.tile_count), 128'(m_tiles));
    chk({tag, "_err"}, 128'(bus.err_no_weight), 128'(m_err));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int ld0, cc0, t;
    logic [1:0] lit_bufs[3];
    rst_n = 1'b0;
    bus.start = 0; bus.desc_word = '0; bus.desc_valid = 0;
    bus.dma_cmd_ready = 1; bus.dma_done = 0; bus.comp_done = 0;
    repeat (3) tick();
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_desc_ready", 128'(bus.desc_ready), 128'd0);
    chk("rst_dma_valid", 128'(bus.dma_cmd_valid), 128'd0);
    chk("rst_tile_count", 128'(bus.tile_count), 128'd0);
    chk("rst_err", 128'(bus.err_no_weight), 128'd0);
    chk("rst_comp_start", 128'(bus.comp_start), 128'd0);
    chk("rst_layer_done", 128'(bus.layer_done), 128'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: weight descriptor alone
    do_start();
    cc0 = comp_count;
    send_desc(32'h1000_0000, 16'h0400, 16'd0, 16'd0, 16'd0, 8'h01, 1);
    chk("t1_buf_wgt", 128'(last_dma_buf), 128'h2);
    chk("t1_len", 128'(last_dma_len), 128'h400);
    chk("t1_desc_ready", 128'(bus.desc_ready), 128'd1);
    chk("t1_no_comp", 128'(comp_count - cc0), 128'd0);

    // 2: activation tile ends the layer
    ld0 = ld_count;
    send_desc(32'h2000_0000, 16'h0200, 16'd8, 16'd8, 16'd16, 8'h02, 1);
    repeat (2) tick();
    chk("t2_buf_act", 128'(last_dma_buf), 128'h0);
    chk("t2_comp_buf", 128'(bus.comp_buf_id), 128'h0);
    chk("t2_tile_h", 128'(bus.comp_tile_h), 128'd8);
    chk("t2_c_in", 128'(bus.comp_c_in), 128'd16);
    chk("t2_layer_done", 128'(ld_count - ld0), 128'd1);
    chk("t2_tile_count", 128'(bus.tile_count), 128'd1);
    chk("t2_busy", 128'(bus.busy), 128'd0);
    chk_model_state("t2");

    // 3: ping/pong across three tiles
    do_start();
    act_buf_log.delete();
    ld0 = ld_count;
    send_desc(32'h3000_0000, 16'h0100, 16'd0, 16'd0, 16'd0, 8'h01, 1);
    send_desc(32'h3100_0000, 16'h0040, 16'd4, 16'd6, 16'd8, 8'h00, 1);
    send_desc(32'h3200_0000, 16'h0044, 16'd5, 16'd7, 16'd9, 8'h00, 1);
    send_desc(32'h3300_0000, 16'h0048, 16'd6, 16'd8, 16'd10, 8'h02, 1);
    repeat (2) tick();
    lit_bufs = '{2'b00, 2'b01, 2'b00};
    chk("t3_buf_log_len", 128'(act_buf_log.size()), 128'd3);
    for (int i = 0; i < 3 && i < act_buf_log.size(); i++)
      chk("t3_buf_seq", 128'(act_buf_log[i]), 128'(lit_bufs[i]));
    chk("t3_tile_count", 128'(bus.tile_count), 128'd3);
    chk("t3_layer_done", 128'(ld_count - ld0), 128'd1);
    chk_model_state("t3");

    // 4: activation before weights is dropped and flagged
    do_start();
    cc0 = comp_count;
    send_desc(32'h4000_0000, 16'h0080, 16'd2, 16'd2, 16'd4, 8'h02, 1);
    chk("t4_err", 128'(bus.err_no_weight), 128'd1);
    chk("t4_no_comp", 128'(comp_count - cc0), 128'd0);
    chk("t4_still_busy", 128'(bus.busy), 128'd1);
    send_desc(32'h4100_0000, 16'h0100, 16'd0, 16'd0, 16'd0, 8'h01, 1);
    send_desc(32'h4200_0000, 16'h0080, 16'd3, 16'd3, 16'd5, 8'h02, 1);
    repeat (2) tick();
    chk("t4_err_sticky", 128'(bus.err_no_weight), 128'd1);
    chk("t4_tile_count", 128'(bus.tile_count), 128'd1);
    chk("t4_busy", 128'(bus.busy), 128'd0);

    // 5: zero-length tile, then a stalled DMA command
    do_start();
    send_desc(32'h5000_0000, 16'h0100, 16'd0, 16'd0, 16'd0, 8'h01, 1);
    send_desc(32'h5100_0000, 16'h0000, 16'd9, 16'd10, 16'd11, 8'h00, 1);
    stall_seen = 0;
    stall_n = 5;
    send_desc(32'h5200_0000, 16'h0080, 16'd12, 16'd13, 16'd14, 8'h02, 1);
    repeat (2) tick();
    chk("t5_stall_cycles", 128'(stall_seen), 128'd5);
    chk("t5_tile_count", 128'(bus.tile_count), 128'd2);
    chk_model_state("t5");

    // 6: reset while computing
    comp_en = 0;
    do_start();
    send_desc(32'h6000_0000, 16'h0100, 16'd0, 16'd0, 16'd0, 8'h01, 1);
    send_desc(32'h6100_0000, 16'h0080, 16'd20, 16'd21, 16'd22, 8'h02, 0);
    t = 0;
    while (!bus.comp_start && t < 300) begin tick(); t++; end
    chk("t6_comp_started", 128'(bus.comp_start), 128'd1);
    repeat (3) tick();
    chk("t6_pre_rst_busy", 128'(bus.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 128'(bus.busy), 128'd0);
    chk("t6_rst_comp_h", 128'(bus.comp_tile_h), 128'd0);
    chk("t6_rst_comp_flags", 128'(bus.comp_flags), 128'd0);
    chk("t6_rst_dma_len", 128'(bus.dma_length), 128'd0);
    exp_dma_q.delete(); exp_comp_q.delete(); exp_ld_q.delete();
    tick();
    rst_n = 1'b1;
    comp_en = 1;
    ld0 = ld_count;
    inject_comp = 1;
    repeat (4) tick();
    chk("t6_late_comp_busy", 128'(bus.busy), 128'd0);
    chk("t6_late_comp_tiles", 128'(bus.tile_count), 128'd0);
    chk("t6_late_comp_ld", 128'(ld_count - ld0), 128'd0);
    do_start();
    send_desc(32'h7000_0000, 16'h0100, 16'd0, 16'd0, 16'd0, 8'h01, 1);
    send_desc(32'h7100_0000, 16'h0080, 16'd8, 16'd8, 16'd16, 8'h02, 1);
    repeat (2) tick();
    chk("t6_tile_count", 128'(bus.tile_count), 128'd1);
    chk("t6_busy", 128'(bus.busy), 128'd0);

    chk("end_dma_q_empty", 128'(exp_dma_q.size()), 128'd0);
    chk("end_comp_q_empty", 128'(exp_comp_q.size()), 128'd0);
    chk("end_ld_q_empty", 128'(exp_ld_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/desc_tile_scheduler.md
Name: desc_tile_scheduler

Overview:
Sequences one layer of tiled work from a stream of 256-bit descriptors (descriptor_t layout) delivered as eight 32-bit words. It assembles each descriptor and issues one DMA load command per descriptor. Weight descriptors go to BUF_WGTBUF. Activation descriptors go to the current ping/pong activation buffer and, once weights are resident, kick the systolic-array compute. It sits between the host descriptor FIFO, the DMA engine and the compute controller.

Parameters:
MAX_TILES, 65535, saturation limit of tile_count.
DESC_WORDS, 8, number of 32-bit words per descriptor; fixed to 8 for descriptor_t.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin layer (accepted only in IDLE)
desc_word  in  32  descriptor word stream
desc_valid  in  1  desc_word valid
desc_ready  out  1  scheduler accepts word
dma_cmd_valid  out  1  DMA command valid
dma_cmd_ready  in  1  DMA accepts command
dma_dram_addr  out  32  descriptor dram_addr
dma_sram_addr  out  16  descriptor sram_addr
dma_length  out  16  bytes to transfer
dma_stride  out  16  2D stride
dma_buf_id  out  2  target buffer_id_t
dma_done  in  1  pulse; transfer complete
comp_start  out  1  one-cycle compute kick
comp_buf_id  out  2  activation buffer to consume (BUF_ACTBUF_A/B)
comp_tile_h  out  16  tile height
comp_tile_w  out  16  tile width
comp_c_in  out  16  input channels
comp_flags  out  8  descriptor flags, passed through
comp_done  in  1  pulse; compute finished
layer_done  out  1  one-cycle pulse after last tile computed
busy  out  1  high in every state except IDLE
err_no_weight  out  1  sticky; activation descriptor arrived with no weights loaded
tile_count  out  16  tiles computed this layer

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; word counter=0; wgt_loaded=0; act_sel=A; tile_count=0; err_no_weight=0. Any in-flight DMA or compute is abandoned. dma_done and comp_done are ignored until the next start.
- States: IDLE, COLLECT, ISSUE_DMA, WAIT_DMA, START_COMP, WAIT_COMP.
- IDLE: desc_ready=0. On start go to COLLECT and clear tile_count, err_no_weight, wgt_loaded and act_sel(=A). start in any other state is ignored.
- COLLECT: desc_ready=1. Each desc_valid&desc_ready beat stores one word; word0 fills bits [255:224] and word7 fills bits [31:0]. After the 8th beat, go to ISSUE_DMA. desc_ready is 0 from that cycle until the FSM next returns to COLLECT.
- Decode: flags = bits[15:8]. If flags[FLAG_IS_WEIGHT]=1, dma_buf_id=BUF_WGTBUF; otherwise dma_buf_id=act_sel.
- ISSUE_DMA: if length==0, skip the DMA and behave as if dma_done occurred that cycle. Otherwise dma_cmd_valid=1 with fields held stable until dma_cmd_ready; on the handshake go to WAIT_DMA. dma_cmd_valid never drops without a handshake.
- WAIT_DMA, on dma_done:
  - Weight descriptor: set wgt_loaded, go to COLLECT.
  - Activation descriptor with wgt_loaded=1: go to START_COMP.
  - Activation descriptor with wgt_loaded=0: set err_no_weight, drop the descriptor, go to COLLECT.
- START_COMP: comp_start=1 for exactly one cycle. comp_* fields are registered from the descriptor and held until the next START_COMP. Go to WAIT_COMP.
- WAIT_COMP, on comp_done:
  - Increment tile_count, saturating at MAX_TILES.
  - Toggle act_sel (A<->B).
  - If flags[FLAG_IS_LAST_TILE]=1: pulse layer_done, clear wgt_loaded, go to IDLE. Otherwise go to COLLECT.
- comp_done and dma_done arriving outside their wait states are ignored. Simultaneous dma_done and comp_done cannot create overlap, because the FSM is strictly sequential.
- Latency: from the last descriptor beat to dma_cmd_valid is 1 cycle. From dma_done (activation) to comp_start is 1 cycle. From comp_done to layer_done is 1 cycle.
- A weight descriptor with FLAG_IS_LAST_TILE set does not end the layer; only activation tiles can end it.

Test Plan:
- Reset then start; send weight desc (dram_addr=0x1000_0000, length=0x0400, flags=0x01) -> dma_cmd with buf_id=2'b10 and length=0x0400; after dma_done, desc_ready=1 and comp_start is not asserted.
- Weight desc, then act desc (length=0x0200, tile_h=8, tile_w=8, c_in=16, flags=0x02) -> dma buf_id=2'b00; comp_start 1 cycle after dma_done with comp_buf_id=00, tile_h=8, c_in=16; after comp_done, layer_done pulses, tile_count=1, busy=0.
- Weight desc plus 3 act descs (last flag on the 3rd) -> act DMA buf_id sequence 00, 01, 00; tile_count=3; exactly one layer_done.
- Act desc with no weight loaded -> err_no_weight=1, no comp_start; a following weight+act pair completes normally and err_no_weight stays 1.
- Act desc with length=0 after weights -> no dma_cmd_valid, comp_start 1 cycle after the descriptor is assembled; hold dma_cmd_ready=0 for 5 cycles on a normal desc -> dma_cmd_valid and fields stay stable.
- rst_n asserted during WAIT_COMP -> outputs 0 immediately; a later comp_done is ignored; a new start plus weight+act sequence completes normally with tile_count=1.
